wb_trace_fifo: RTL
==================

# wb_trace_fifo

Capture buffer directly downstream of the pipelined processor's final write-back mux. Every register-file write (normal or matrix-result) is stamped with a free-running cycle count and queued. A valid/ready port drains the queue to a debug or host consumer. The processor is never back-pressured: when the buffer is full, new writes are dropped and counted.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of 2, ≥2
- DATA_W, 8, write-back data width
- REG_W, 3, destination register index width
- STAMP_W, 8, cycle-stamp width

Ports:
- CLK  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- wb_write_in  in  1  final register-file write enable (post-mux)
- wb_destreg_in  in  REG_W  final destination register
- wb_data_in  in  DATA_W  final write data
- wb_matrix_in  in  1  high when the write comes from the matrix-result sequencer
- capture_en  in  1  capture is allowed only while high
- clear  in  1  synchronous flush of queue and status
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_data  out  STAMP_W+1+REG_W+DATA_W  head entry: {stamp, matrix, destreg, data}
- count  out  log2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; at least one write was dropped
- drop_count  out  8  number of dropped writes, saturates at 255

## Operation
- Reset (reset==0 at an edge): pointers, count, stamp, overflow and drop_count are set to 0, so out_valid=0 and out_data=0. Storage contents are don't-care.
- Stamp counter: STAMP_W bits. It increments every cycle independent of capture_en and wraps 255→0. A captured entry records the stamp value present in its push cycle.
- push = wb_write_in & capture_en. pop = out_valid & out_ready.
- Push when not full: write the entry at wr_ptr, then advance wr_ptr.
- Push when full and no pop: drop the write. Set overflow and increment drop_count, holding it at 255.
- Push when full with pop in the same cycle: accept the push. count is unchanged and nothing is dropped.
- Pop when empty: not possible, because out_valid=0.
- Simultaneous push and pop when not empty: count is unchanged and both pointers advance.
- clear has priority over push and pop in the same cycle. It empties the queue and zeroes overflow and drop_count. The stamp counter is not affected.
- Pointers are log2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty.
  - full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}
  - empty = wr_ptr == rd_ptr
- wb_write_in with capture_en=0: ignored, and not counted as a drop.

## Timing
- Push latency: 1 cycle. An entry pushed at edge N drives out_valid/out_data after edge N. There is no same-cycle bypass.
- out_data is first-word-fall-through. It is valid whenever out_valid=1 and is held stable until popped.
- The consumer may hold out_ready high continuously. That sustains 1 pop per cycle.
- count, overflow and drop_count are registered and update on the same edge as the event that changes them.
- A reset or clear asserted mid-drain discards in-flight entries. out_valid is 0 on the following cycle.

## Structure
- Shared package wb_trace_pkg:
  - localparams for field widths
  - ENTRY_W
  - field offsets for stamp, matrix, destreg and data
  - a packed struct type for the entry
- Sub-module wb_trace_mem:
  - DEPTH×ENTRY_W register array
  - one synchronous write port, one combinational read port
  - no reset on storage
- Top level holds pointers, count, stamp, status and handshake logic.

## Test plan
- Reset then idle: after reset=0 for 2 cycles then release, out_valid=0, count=0, overflow=0, drop_count=0, out_data=0.
- Single write, pop timing: write reg 3, data 0x5A, matrix 0 at stamp 0x10. On the next cycle out_data={0x10,0,3,0x5A} and out_valid=1. With out_ready=1, count returns to 0 one cycle later.
- Fill and overflow (DEPTH=8, out_ready=0): issue 10 consecutive writes with data 1..10. Required: count=8, overflow=1, drop_count=2, and the drain yields data 1..8 in order.
- Full with simultaneous push and pop: from full, hold out_ready=1 and write data 0xEE. count stays 8, drop_count is unchanged, and 0xEE appears as the 8th entry after the current head.
- Matrix write-back burst: 4 back-to-back matrix writes (regs 4..7, matrix=1) interleaved with capture_en=0 on the 3rd. Exactly 3 entries are queued with matrix=1 and consecutive stamps except for the gap. drop_count=0.
- Clear priority and stamp wrap: run until stamp=0xFF, then push and clear in the same cycle. Next cycle: count=0, out_valid=0. The following push records stamp 0x01, showing the counter wrapped and was not reset.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared field widths, entry layout and offsets for the write-back trace buffer.
package wb_trace_pkg;

    localparam int STAMP_W_DEF = 8;
    localparam int MATRIX_W    = 1;
    localparam int REG_W_DEF   = 3;
    localparam int DATA_W_DEF  = 8;
    localparam int DROP_W      = 8;

    localparam int ENTRY_W     = STAMP_W_DEF + MATRIX_W + REG_W_DEF + DATA_W_DEF;

    localparam int DATA_LSB    = 0;
    localparam int DESTREG_LSB = DATA_LSB + DATA_W_DEF;
    localparam int MATRIX_LSB  = DESTREG_LSB + REG_W_DEF;
    localparam int STAMP_LSB   = MATRIX_LSB + MATRIX_W;

    typedef struct packed {
        logic [STAMP_W_DEF-1:0] stamp;
        logic                   matrix;
        logic [REG_W_DEF-1:0]   destreg;
        logic [DATA_W_DEF-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_trace_mem.sv
// Entry storage: one synchronous write port, one combinational read port, no reset.
module wb_trace_mem
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Cycle-stamped capture queue for register-file write-backs with a valid/ready drain port.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int STAMP_W = STAMP_W_DEF
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             wb_write_in,
    input  logic [REG_W-1:0]                 wb_destreg_in,
    input  logic [DATA_W-1:0]                wb_data_in,
    input  logic                             wb_matrix_in,
    input  logic                             capture_en,
    input  logic                             clear,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [STAMP_W+1+REG_W+DATA_W-1:0] out_data,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             overflow,
    output logic [DROP_W-1:0]                drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = STAMP_W + 1 + REG_W + DATA_W;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        if (v == {DROP_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      count_q, count_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_count_q, drop_count_d;

    logic          full, empty, push, pop, accept, drop, mem_we;
    logic [EW-1:0] wr_entry, rd_entry;

    always_comb begin
        full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        empty    = (wr_ptr_q == rd_ptr_q);
        push     = wb_write_in & capture_en;
        pop      = ~empty & out_ready;
        // A pop in the same cycle frees the slot, so a push into a full queue still lands.
        accept   = push & (~full | pop);
        drop     = push & full & ~pop;
        mem_we   = accept & ~clear;
        wr_entry = {stamp_q, wb_matrix_in, wb_destreg_in, wb_data_in};

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        stamp_d      = stamp_q + 1'b1;

        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d   = 1'b1;
                drop_count_d = sat_inc(drop_count_q);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            stamp_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            stamp_q      <= stamp_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    wb_trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_entry)
    );

    // Storage is never reset, so the head is masked to zero while the queue is empty.
    assign out_valid  = ~empty;
    assign out_data   = empty ? '0 : rd_entry;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
